// File: rtl/triage_pkg.sv
// Definitions shared by the triage core and the actuator driver: level encodings,
// the legal actuator patterns and the FSM state encodings.
package triage_pkg;

  localparam logic [5:0] PAT_L0 = 6'b000000;
  localparam logic [5:0] PAT_L1 = 6'b001100;
  localparam logic [5:0] PAT_L2 = 6'b011010;
  localparam logic [5:0] PAT_L3 = 6'b111111;

  localparam logic [1:0] LVL_0 = 2'd0;
  localparam logic [1:0] LVL_1 = 2'd1;
  localparam logic [1:0] LVL_2 = 2'd2;
  localparam logic [1:0] LVL_3 = 2'd3;

  typedef enum logic [2:0] {
    DRV_OFF      = 3'd0,
    DRV_STEADY   = 3'd1,
    DRV_BLINK    = 3'd2,
    DRV_ALARM    = 3'd3,
    DRV_SILENCED = 3'd4
  } drv_state_e;

  typedef enum logic [1:0] {
    CORE_IDLE         = 2'd0,
    CORE_OBSERVATION  = 2'd1,
    CORE_PRE_CRITICAL = 2'd2,
    CORE_CRITICAL     = 2'd3
  } core_state_e;

  typedef struct packed {
    logic [1:0] level;
    logic       illegal;
    logic [5:0] pattern;
  } decode_t;

  // Unknown codes fail safe to the highest level with every line driven.
  function automatic decode_t decode_code(input logic [5:0] code);
    decode_t d;
    d.illegal = 1'b0;
    d.pattern = code;
    case (code)
      PAT_L0:  d.level = LVL_0;
      PAT_L1:  d.level = LVL_1;
      PAT_L2:  d.level = LVL_2;
      PAT_L3:  d.level = LVL_3;
      default: begin
        d.level   = LVL_3;
        d.illegal = 1'b1;
        d.pattern = PAT_L3;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/triage_actuator_driver_tick_gen.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and flags the last count as a tick.
module triage_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)              cnt_q <= '0;
    else if (cnt_q == LAST) cnt_q <= '0;
    else                    cnt_q <= cnt_q + 1'b1;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/triage_actuator_driver.sv
// Filters the triage actuator code and drives the actuator lines with steady,
// blinking or siren patterns, with nurse-acknowledge silencing.
//
// state        | meaning
// DRV_OFF      | level 0, all lines low
// DRV_STEADY   | level 1, accepted code driven steadily
// DRV_BLINK    | level 2, accepted code gated by blink phase
// DRV_ALARM    | level 3, indicators on, siren line follows phase
// DRV_SILENCED | level 3 after ACK, siren off until silence timer expires
module triage_actuator_driver #(
  parameter int TICK_DIV      = 50000,
  parameter int BLINK_TICKS   = 250,
  parameter int SILENCE_TICKS = 1000,
  parameter int STABLE_CYC    = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] a_in_i,
  input  logic       ack_i,
  output logic [5:0] drv_o,
  output logic [1:0] level_o,
  output logic       alarm_o,
  output logic       silenced_o,
  output logic       fault_o
);
  import triage_pkg::*;

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int PW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int LW = (SILENCE_TICKS > 1) ? $clog2(SILENCE_TICKS) : 1;
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC);
  localparam logic [PW-1:0] PH_LAST  = PW'(BLINK_TICKS - 1);
  localparam logic [LW-1:0] SIL_LAST = LW'(SILENCE_TICKS - 1);

  logic            tick;
  logic [5:0]      samp_q, acc_q, acc_d, drv_q, drv_d;
  logic [SW-1:0]   stab_q, stab_d;
  logic [PW-1:0]   ph_cnt_q, ph_cnt_d;
  logic [LW-1:0]   sil_q, sil_d;
  logic            phase_q, phase_d, ack_q, ack_edge, enter;
  logic [1:0]      level_q;
  logic            alarm_q, silenced_q, fault_q;
  drv_state_e      state_q, state_d;
  decode_t         dec;

  triage_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  // Stability count saturates, so a held value keeps re-accepting itself harmlessly.
  always_comb begin
    if (a_in_i == samp_q) stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
    else                  stab_d = SW'(1);
    acc_d = (stab_d == STAB_MAX) ? a_in_i : acc_q;
  end

  assign dec      = decode_code(acc_q);
  assign ack_edge = ack_i & ~ack_q;

  always_comb begin
    state_d  = state_q;
    ph_cnt_d = ph_cnt_q;
    phase_d  = phase_q;
    sil_d    = sil_q;
    enter    = 1'b0;
    if (dec.level != level_q) begin
      enter = 1'b1;
      case (dec.level)
        LVL_0:   state_d = DRV_OFF;
        LVL_1:   state_d = DRV_STEADY;
        LVL_2:   state_d = DRV_BLINK;
        default: state_d = DRV_ALARM;
      endcase
    end else if (state_q == DRV_ALARM && ack_edge) begin
      state_d = DRV_SILENCED;
      enter   = 1'b1;
    end else if (state_q == DRV_SILENCED && tick && sil_q == SIL_LAST) begin
      state_d = DRV_ALARM;
      enter   = 1'b1;
    end

    if (enter) begin
      ph_cnt_d = '0;
      phase_d  = 1'b1;
      sil_d    = '0;
    end else if (tick) begin
      if (ph_cnt_q == PH_LAST) begin
        ph_cnt_d = '0;
        phase_d  = ~phase_q;
      end else begin
        ph_cnt_d = ph_cnt_q + 1'b1;
      end
      if (state_q == DRV_SILENCED) sil_d = sil_q + 1'b1;
    end

    case (state_d)
      DRV_STEADY:   drv_d = dec.pattern;
      DRV_BLINK:    drv_d = dec.pattern & {6{phase_d}};
      DRV_ALARM:    drv_d = {phase_d, 5'b11111};
      DRV_SILENCED: drv_d = {1'b0, 5'b11111};
      default:      drv_d = 6'b000000;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      samp_q     <= '0;
      stab_q     <= '0;
      acc_q      <= '0;
      ack_q      <= 1'b0;
      state_q    <= DRV_OFF;
      ph_cnt_q   <= '0;
      phase_q    <= 1'b1;
      sil_q      <= '0;
      drv_q      <= '0;
      level_q    <= '0;
      alarm_q    <= 1'b0;
      silenced_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      samp_q     <= a_in_i;
      stab_q     <= stab_d;
      acc_q      <= acc_d;
      ack_q      <= ack_i;
      state_q    <= state_d;
      ph_cnt_q   <= ph_cnt_d;
      phase_q    <= phase_d;
      sil_q      <= sil_d;
      drv_q      <= drv_d;
      level_q    <= dec.level;
      alarm_q    <= (state_d == DRV_ALARM) || (state_d == DRV_SILENCED);
      silenced_q <= (state_d == DRV_SILENCED);
      fault_q    <= dec.illegal;
    end
  end

  assign drv_o      = drv_q;
  assign level_o    = level_q;
  assign alarm_o    = alarm_q;
  assign silenced_o = silenced_q;
  assign fault_o    = fault_q;

endmodule

// File: tb/tb_triage_actuator_driver.sv
// Bench for triage_actuator_driver: directed scenarios plus random code/ACK/reset
// traffic, checked every cycle against a time-based reference model.
module tb_triage_actuator_driver;
  localparam int TD = 4;
  localparam int BT = 2;
  localparam int ST = 5;
  localparam int SC = 3;

  localparam int S_OFF = 0, S_STEADY = 1, S_BLINK = 2, S_ALARM = 3, S_SIL = 4;

  logic       clk = 1'b0;
  logic       rst, ack;
  logic [5:0] a_in;
  logic [5:0] drv;
  logic [1:0] level;
  logic       alarm, silenced, fault;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_cyc, m_state, m_ticks;
  logic [5:0] m_hist[$];
  logic [5:0] m_acc, m_drv;
  logic       m_ack_prev, m_fault, m_alarm, m_sil;
  logic [1:0] m_level;

  triage_actuator_driver #(
    .TICK_DIV(TD), .BLINK_TICKS(BT), .SILENCE_TICKS(ST), .STABLE_CYC(SC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .a_in_i(a_in), .ack_i(ack),
    .drv_o(drv), .level_o(level), .alarm_o(alarm), .silenced_o(silenced), .fault_o(fault)
  );

  always #5 clk = ~clk;

  function automatic int lvl_of(input logic [5:0] c);
    if (c == 6'b000000) return 0;
    if (c == 6'b001100) return 1;
    if (c == 6'b011010) return 2;
    return 3;
  endfunction

  function automatic logic is_legal(input logic [5:0] c);
    return (c == 6'b000000) || (c == 6'b001100) || (c == 6'b011010) || (c == 6'b111111);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic model(input logic [5:0] a, input logic k, input logic r);
    logic       tick, phase, same;
    int         lvl;
    logic [5:0] acc_old;
    if (r) begin
      m_cyc = 0; m_hist.delete(); m_acc = '0; m_state = S_OFF; m_ticks = 0;
      m_ack_prev = 1'b0; m_level = '0; m_fault = 1'b0; m_drv = '0;
      m_alarm = 1'b0; m_sil = 1'b0;
      return;
    end
    tick = ((m_cyc % TD) == TD - 1);
    m_cyc++;
    acc_old = m_acc;
    lvl = lvl_of(acc_old);
    if (lvl != int'(m_level)) begin
      m_state = lvl; m_ticks = 0;
    end else if (m_state == S_ALARM && k && !m_ack_prev) begin
      m_state = S_SIL; m_ticks = 0;
    end else if (tick) begin
      m_ticks++;
      if (m_state == S_SIL && m_ticks == ST) begin
        m_state = S_ALARM; m_ticks = 0;
      end
    end
    phase = (((m_ticks / BT) % 2) == 0);
    case (m_state)
      S_OFF:    m_drv = 6'b000000;
      S_STEADY: m_drv = acc_old;
      S_BLINK:  m_drv = acc_old & {6{phase}};
      S_ALARM:  m_drv = {phase, 5'b11111};
      default:  m_drv = 6'b011111;
    endcase
    m_level = lvl[1:0];
    m_fault = !is_legal(acc_old);
    m_alarm = (m_state == S_ALARM) || (m_state == S_SIL);
    m_sil   = (m_state == S_SIL);
    m_ack_prev = k;
    m_hist.push_back(a);
    if (m_hist.size() > SC) void'(m_hist.pop_front());
    if (m_hist.size() == SC) begin
      same = 1'b1;
      foreach (m_hist[i]) if (m_hist[i] != a) same = 1'b0;
      if (same) m_acc = a;
    end
  endtask

  task automatic step(input logic [5:0] a, input logic k, input logic r);
    a_in = a; ack = k; rst = r;
    @(posedge clk);
    #1;
    model(a, k, r);
    chk("drv",      {2'b00, drv},   {2'b00, m_drv});
    chk("level",    {6'b0, level},  {6'b0, m_level});
    chk("alarm",    {7'b0, alarm},  {7'b0, m_alarm});
    chk("silenced", {7'b0, silenced}, {7'b0, m_sil});
    chk("fault",    {7'b0, fault},  {7'b0, m_fault});
  endtask

  task automatic hold(input logic [5:0] a, input logic k, input int n);
    for (int i = 0; i < n; i++) step(a, k, 1'b0);
  endtask

  initial begin
    logic [5:0] code;
    logic       k;
    int         len;
    a_in = '0; ack = 1'b0; rst = 1'b1;
    m_cyc = 0;

    // reset state
    step(6'b000000, 1'b0, 1'b1);
    step(6'b000000, 1'b0, 1'b1);
    chk("rst_drv",   {2'b00, drv}, 8'h00);
    chk("rst_alarm", {7'b0, alarm}, 8'h00);

    // scenario 1: accept latency STABLE_CYC+1
    hold(6'b001100, 1'b0, 3);
    chk("s1_early_drv", {2'b00, drv}, 8'h00);
    step(6'b001100, 1'b0, 1'b0);
    chk("s1_drv",   {2'b00, drv}, 8'h0C);
    chk("s1_level", {6'b0, level}, 8'h01);
    hold(6'b001100, 1'b0, 16);

    // scenario 2: blinking
    hold(6'b011010, 1'b0, 40);

    // scenario 3: short glitch is rejected
    hold(6'b000000, 1'b0, 10);
    hold(6'b111111, 1'b0, 2);
    hold(6'b000000, 1'b0, 6);
    chk("s3_level", {6'b0, level}, 8'h00);
    chk("s3_drv",   {2'b00, drv}, 8'h00);

    // scenario 4: alarm, silence, expiry with ACK still held
    hold(6'b111111, 1'b0, 24);
    hold(6'b111111, 1'b1, 10);
    chk("s4_silenced", {7'b0, silenced}, 8'h01);
    chk("s4_sil_drv",  {2'b00, drv}, 8'h1F);
    hold(6'b111111, 1'b1, 30);
    chk("s4_resumed", {7'b0, silenced}, 8'h00);
    hold(6'b111111, 1'b0, 6);

    // scenario 5: illegal code, then legal swap at level 3
    hold(6'b101010, 1'b0, 20);
    chk("s5_fault", {7'b0, fault}, 8'h01);
    chk("s5_level", {6'b0, level}, 8'h03);
    hold(6'b101010, 1'b1, 3);
    hold(6'b101010, 1'b0, 30);
    hold(6'b111111, 1'b0, 12);
    chk("s5_fault_clr", {7'b0, fault}, 8'h00);

    // level drop while silenced
    hold(6'b111111, 1'b1, 4);
    hold(6'b001100, 1'b0, 10);
    chk("drop_level", {6'b0, level}, 8'h01);

    // scenario 6: reset while silenced
    hold(6'b111111, 1'b0, 8);
    hold(6'b111111, 1'b1, 4);
    step(6'b111111, 1'b1, 1'b1);
    chk("s6_rst_drv", {2'b00, drv}, 8'h00);
    hold(6'b111111, 1'b1, 3);
    chk("s6_pre_alarm", {7'b0, alarm}, 8'h00);
    step(6'b111111, 1'b1, 1'b0);
    chk("s6_alarm", {7'b0, alarm}, 8'h01);
    hold(6'b111111, 1'b0, 10);

    // random traffic
    k = 1'b0;
    for (int seg = 0; seg < 80; seg++) begin
      case ($urandom_range(0, 5))
        0: code = 6'b000000;
        1: code = 6'b001100;
        2: code = 6'b011010;
        3: code = 6'b111111;
        default: code = 6'($urandom_range(0, 63));
      endcase
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) k = ~k;
        step(code, k, ($urandom_range(0, 199) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
